// File: rtl/episode_monitor_if.sv
// Step-strobe and host-readout bus between the POMDP simulator, the episode
// monitor and the host. The simulator/host side is the master.
interface episode_monitor_if #(
    parameter int STEP_W = 16
) ();
    logic              step_valid;
    logic [1:0]        action;
    logic              observation;
    logic              cur_state;
    logic [31:0]       reward;
    logic              rd_en;
    logic              rd_valid;
    logic [STEP_W+19:0] rd_data;

    modport master (
        output step_valid, action, observation, cur_state, reward, rd_en,
        input  rd_valid, rd_data
    );

    modport slave (
        input  step_valid, action, observation, cur_state, reward, rd_en,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/episode_monitor.sv
// Episode monitor: records one trajectory record per simulator step into a
// show-ahead FIFO. Optional per-action histogram under macro TRAJ_STATS_EN.
module episode_monitor #(
    parameter int DEPTH  = 16,
    parameter int STEP_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [STEP_W-1:0]     max_steps,
    episode_monitor_if.slave      bus,
    output logic [STEP_W-1:0]     step_count,
    output logic                  running,
    output logic                  episode_done,
    output logic                  overflow,
    output logic [4*STEP_W-1:0]   act_hist
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = STEP_W + 20;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;
    logic [STEP_W-1:0] limit_q, limit_d;
    logic [31:0]       prev_reward_q, prev_reward_d;
    logic              overflow_q, overflow_d;
    logic [REC_W-1:0]  mem_q [DEPTH];

    logic              empty, full, pop, accept, wr_en;
    logic [REC_W-1:0]  wr_rec;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = bus.rd_en && !empty;
    assign accept = (state_q == S_RUN) && bus.step_valid && !start && !abort;
    assign wr_rec = {step_count_q, bus.action, bus.observation, bus.cur_state,
                     16'(bus.reward - prev_reward_q)};

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        step_count_d  = step_count_q;
        limit_d       = limit_q;
        prev_reward_d = prev_reward_q;
        overflow_d    = overflow_q;
        wr_en         = 1'b0;
        if (start) begin
            state_d       = S_RUN;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            step_count_d  = '0;
            limit_d       = max_steps;
            prev_reward_d = '0;
            overflow_d    = 1'b0;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            if (state_q == S_RUN && abort) begin
                state_d = S_DONE;
            end else if (accept) begin
                prev_reward_d = bus.reward;
                step_count_d  = (&step_count_q) ? step_count_q
                                                : step_count_q + STEP_W'(1);
                if (limit_q != '0 && (step_count_q + STEP_W'(1)) == limit_q)
                    state_d = S_DONE;
                // A simultaneous pop frees the slot, so a full FIFO still accepts.
                if (!full || pop) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + (AW+1)'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            step_count_q  <= '0;
            limit_q       <= '0;
            prev_reward_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            step_count_q  <= step_count_d;
            limit_q       <= limit_d;
            prev_reward_q <= prev_reward_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
    end

    assign bus.rd_valid = !empty;
    assign bus.rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign step_count   = step_count_q;
    assign running      = (state_q == S_RUN);
    assign episode_done = (state_q == S_DONE);
    assign overflow     = overflow_q;

`ifdef TRAJ_STATS_EN
    logic [3:0][STEP_W-1:0] act_cnt_q, act_cnt_d;

    // Counts every accepted step, including ones whose record was dropped.
    always_comb begin
        act_cnt_d = act_cnt_q;
        if (start)
            act_cnt_d = '0;
        else if (accept && !(&act_cnt_q[bus.action]))
            act_cnt_d[bus.action] = act_cnt_q[bus.action] + STEP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) act_cnt_q <= '0;
        else        act_cnt_q <= act_cnt_d;
    end

    assign act_hist = act_cnt_q;
`else
    assign act_hist = '0;
`endif
endmodule

// File: tb/tb_episode_monitor.sv
// Directed self-checking bench for episode_monitor (DEPTH=16, STEP_W=16).
module tb_episode_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] max_steps = '0;
    logic [15:0] step_count;
    logic        running, episode_done, overflow;
    logic [63:0] act_hist;
    int          n_chk = 0;
    int          n_fail = 0;

    episode_monitor_if #(.STEP_W(16)) bus ();

    episode_monitor #(.DEPTH(16), .STEP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .max_steps(max_steps), .bus(bus), .step_count(step_count),
        .running(running), .episode_done(episode_done),
        .overflow(overflow), .act_hist(act_hist)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] rec(input logic [15:0] idx, input logic [1:0] a,
                                        input logic o, input logic s, input logic [15:0] d);
        return {idx, a, o, s, d};
    endfunction

    task automatic do_start(input logic [15:0] ms);
        start = 1'b1; max_steps = ms;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_step(input logic [1:0] a, input logic o, input logic s, input logic [31:0] r);
        bus.step_valid = 1'b1; bus.action = a; bus.observation = o;
        bus.cur_state = s; bus.reward = r;
        @(negedge clk);
        bus.step_valid = 1'b0;
    endtask

    task automatic do_pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if ({bus.rd_valid, running, episode_done, overflow} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.rd_valid, running, episode_done, overflow}); end
        n_chk++; if (bus.rd_data !== 36'h0) begin
            n_fail++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        n_chk++; if (step_count !== 16'd0 || act_hist !== 64'd0) begin
            n_fail++; $display("FAIL reset_counts: got %h/%h expected 0/0", step_count, act_hist); end
        rst_n = 1'b1;
        @(negedge clk);
        do_pop();
        n_chk++; if (bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_pop: rd_valid got %b expected 0", bus.rd_valid); end
        do_step(2'd1, 1'b0, 1'b0, 32'd9);
        n_chk++; if (step_count !== 16'd0 || bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_step: got %0d/%b expected 0/0", step_count, bus.rd_valid); end
    endtask

    task automatic test_limit();
        logic [35:0] exp_r [3];
        exp_r[0] = rec(16'd0, 2'd0, 1'b0, 1'b0, 16'd5);
        exp_r[1] = rec(16'd1, 2'd2, 1'b1, 1'b0, 16'd7);
        exp_r[2] = rec(16'd2, 2'd2, 1'b0, 1'b1, 16'hFFFE);
        do_start(16'd3);
        n_chk++; if (running !== 1'b1) begin
            n_fail++; $display("FAIL start_running: got %b expected 1", running); end
        do_step(2'd0, 1'b0, 1'b0, 32'd5);
        do_step(2'd2, 1'b1, 1'b0, 32'd12);
        n_chk++; if (episode_done !== 1'b0 || step_count !== 16'd2) begin
            n_fail++; $display("FAIL limit_early: got done=%b cnt=%0d expected 0/2", episode_done, step_count); end
        do_step(2'd2, 1'b0, 1'b1, 32'd10);
        n_chk++; if (episode_done !== 1'b1 || running !== 1'b0 || step_count !== 16'd3) begin
            n_fail++; $display("FAIL limit_done: got done=%b run=%b cnt=%0d expected 1/0/3", episode_done, running, step_count); end
        do_step(2'd1, 1'b0, 1'b0, 32'd99);
        n_chk++; if (step_count !== 16'd3) begin
            n_fail++; $display("FAIL done_ignores_step: got %0d expected 3", step_count); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_r[i]) begin
                n_fail++; $display("FAIL limit_rec%0d: got %b/%h expected 1/%h", i, bus.rd_valid, bus.rd_data, exp_r[i]); end
            do_pop();
        end
        n_chk++; if (bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL limit_drained: rd_valid got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_overflow();
        do_start(16'd0);
        for (int i = 0; i < 20; i++) do_step(2'(i), 1'(i), 1'(i >> 1), 32'(i + 1));
        n_chk++; if (overflow !== 1'b1 || step_count !== 16'd20 || running !== 1'b1) begin
            n_fail++; $display("FAIL ovf_state: got ovf=%b cnt=%0d run=%b expected 1/20/1", overflow, step_count, running); end
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (bus.rd_data !== rec(16'(i), 2'(i), 1'(i), 1'(i >> 1), 16'd1)) begin
                n_fail++; $display("FAIL ovf_rec%0d: got %h expected %h", i, bus.rd_data, rec(16'(i), 2'(i), 1'(i), 1'(i >> 1), 16'd1)); end
            do_pop();
        end
        n_chk++; if (bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained: rd_valid got %b expected 0", bus.rd_valid); end
        do_start(16'd0);
        n_chk++; if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_start(16'd0);
        for (int i = 1; i <= 16; i++) do_step(2'd0, 1'b0, 1'b0, 32'(i));
        bus.step_valid = 1'b1; bus.rd_en = 1'b1; bus.action = 2'd1;
        bus.observation = 1'b0; bus.cur_state = 1'b0; bus.reward = 32'd100;
        @(negedge clk);
        bus.step_valid = 1'b0; bus.rd_en = 1'b0;
        n_chk++; if (overflow !== 1'b0 || step_count !== 16'd17) begin
            n_fail++; $display("FAIL fpp_state: got ovf=%b cnt=%0d expected 0/17", overflow, step_count); end
        for (int i = 1; i < 16; i++) begin
            n_chk++; if (bus.rd_data !== rec(16'(i), 2'd0, 1'b0, 1'b0, 16'd1)) begin
                n_fail++; $display("FAIL fpp_rec%0d: got %h expected %h", i, bus.rd_data, rec(16'(i), 2'd0, 1'b0, 1'b0, 16'd1)); end
            do_pop();
        end
        n_chk++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rec(16'd16, 2'd1, 1'b0, 1'b0, 16'd84)) begin
            n_fail++; $display("FAIL fpp_newest: got %b/%h expected 1/%h", bus.rd_valid, bus.rd_data, rec(16'd16, 2'd1, 1'b0, 1'b0, 16'd84)); end
        do_pop();
        n_chk++; if (bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL fpp_drained: rd_valid got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_abort();
        do_start(16'd0);
        do_step(2'd3, 1'b1, 1'b1, 32'd3);
        do_step(2'd1, 1'b0, 1'b1, 32'd8);
        abort = 1'b1; bus.step_valid = 1'b1; bus.reward = 32'd50;
        @(negedge clk);
        abort = 1'b0; bus.step_valid = 1'b0;
        n_chk++; if (episode_done !== 1'b1 || running !== 1'b0 || step_count !== 16'd2) begin
            n_fail++; $display("FAIL abort_state: got done=%b run=%b cnt=%0d expected 1/0/2", episode_done, running, step_count); end
        do_step(2'd0, 1'b0, 1'b0, 32'd60);
        n_chk++; if (step_count !== 16'd2) begin
            n_fail++; $display("FAIL abort_ignore: got %0d expected 2", step_count); end
        n_chk++; if (bus.rd_data !== rec(16'd0, 2'd3, 1'b1, 1'b1, 16'd3)) begin
            n_fail++; $display("FAIL abort_rec0: got %h expected %h", bus.rd_data, rec(16'd0, 2'd3, 1'b1, 1'b1, 16'd3)); end
        do_pop();
        n_chk++; if (bus.rd_data !== rec(16'd1, 2'd1, 1'b0, 1'b1, 16'd5)) begin
            n_fail++; $display("FAIL abort_rec1: got %h expected %h", bus.rd_data, rec(16'd1, 2'd1, 1'b0, 1'b1, 16'd5)); end
        do_pop();
        n_chk++; if (bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_drained: rd_valid got %b expected 0", bus.rd_valid); end
    endtask

    task automatic test_restart();
        do_start(16'd0);
        for (int i = 1; i <= 5; i++) do_step(2'd2, 1'b0, 1'b0, 32'(10 * i));
        n_chk++; if (bus.rd_valid !== 1'b1 || step_count !== 16'd5) begin
            n_fail++; $display("FAIL rst_pre: got %b/%0d expected 1/5", bus.rd_valid, step_count); end
        start = 1'b1; max_steps = 16'd0; bus.step_valid = 1'b1; bus.reward = 32'd999;
        @(negedge clk);
        start = 1'b0; bus.step_valid = 1'b0;
        n_chk++; if (bus.rd_valid !== 1'b0 || step_count !== 16'd0 || overflow !== 1'b0 || running !== 1'b1) begin
            n_fail++; $display("FAIL rst_flush: got v=%b cnt=%0d ovf=%b run=%b expected 0/0/0/1", bus.rd_valid, step_count, overflow, running); end
        do_step(2'd3, 1'b1, 1'b1, 32'd77);
        n_chk++; if (bus.rd_data !== rec(16'd0, 2'd3, 1'b1, 1'b1, 16'd77) || step_count !== 16'd1) begin
            n_fail++; $display("FAIL rst_first: got %h/%0d expected %h/1", bus.rd_data, step_count, rec(16'd0, 2'd3, 1'b1, 1'b1, 16'd77)); end
    endtask

    task automatic test_act_hist();
        logic [63:0] exp_h;
`ifdef TRAJ_STATS_EN
        exp_h = {16'd1, 16'd2, 16'd0, 16'd1};
`else
        exp_h = 64'd0;
`endif
        do_start(16'd0);
        n_chk++; if (act_hist !== 64'd0) begin
            n_fail++; $display("FAIL hist_clear: got %h expected 0", act_hist); end
        do_step(2'd0, 1'b0, 1'b0, 32'd1);
        do_step(2'd2, 1'b0, 1'b0, 32'd2);
        do_step(2'd2, 1'b0, 1'b0, 32'd3);
        do_step(2'd3, 1'b0, 1'b0, 32'd4);
        n_chk++; if (act_hist !== exp_h) begin
            n_fail++; $display("FAIL act_hist: got %h expected %h", act_hist, exp_h); end
    endtask

    initial begin
        bus.step_valid = 1'b0; bus.action = '0; bus.observation = 1'b0;
        bus.cur_state = 1'b0; bus.reward = '0; bus.rd_en = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_limit();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_restart();
        test_act_hist();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
